line_buf_ctrl: RTL and testbench
================================

LINE_BUF_CTRL -- requirements
Module: line_buf_ctrl

Interface
REQ-001 SHALL have parameter IMG_WIDTH, default 640, pixels per line; also line-buffer tap length.
REQ-002 SHALL have parameter IMG_HEIGHT, default 480, lines per frame.
REQ-003 clk  in  1  system clock; all state on rising edge.
REQ-004 rst_n  in  1  reset; asynchronous, active-low.
REQ-005 per_frame_vsync / per_frame_href / per_frame_clken  in  1 each  input frame sync, line valid, pixel strobe.
REQ-006 per_img_bit  in  1  binary pixel (motion mask).
REQ-007 lb_shift  out  1  shift enable to 2-line shift buffer; lb_sr_in  out  1  bit written into buffer.
REQ-008 lb_taps  in  2  buffer taps: [0] one line back, [1] two lines back (same column).
REQ-009 matrix_p11..p33  out  1 each  3x3 window; row 1 oldest line, column 1 oldest pixel.
REQ-010 post_frame_vsync / post_frame_href / post_frame_clken  out  1 each  input syncs delayed to align with matrix.
REQ-011 window_valid  out  1  matrix holds a usable window.
REQ-012 col_cnt  out  10  accepted pixels in current line; row_cnt  out  9  completed lines in frame.
REQ-013 line_err  out  1  sticky: line exceeded IMG_WIDTH or frame exceeded IMG_HEIGHT.

Function
REQ-014 FSM states SHALL be IDLE, WAIT_LINE, LINE, FRAME_DONE.
REQ-015 IDLE -> WAIT_LINE on vsync rising edge (vsync high now, registered vsync low); no shifting in IDLE.
REQ-016 Vsync rising edge in ANY state SHALL clear col_cnt, row_cnt, line_err and enter WAIT_LINE.
REQ-017 WAIT_LINE -> LINE when href=1; LINE -> WAIT_LINE on href falling edge, row_cnt +1, col_cnt cleared same edge.
REQ-018 LINE -> FRAME_DONE when row_cnt increment reaches IMG_HEIGHT; FRAME_DONE ignores pixels until next vsync rising edge.
REQ-019 Stage 1: per_img_bit and (clken & href & state==LINE) registered to bit_d1, acc_d1; lb_shift=acc_d1, lb_sr_in=bit_d1.
REQ-020 When acc_d1=1 and col_cnt=IMG_WIDTH, lb_shift SHALL be forced 0, line_err set, col_cnt held (saturate).
REQ-021 Otherwise acc_d1=1 SHALL increment col_cnt and shift window: column 3 <- {lb_taps[1], lb_taps[0], bit_d1} (rows 1..3), columns 1,2 shift left.
REQ-022 lb_taps SHALL be sampled in the cycle lb_shift is high (pre-shift values).
REQ-023 Matrix update latency: pixel sampled at edge N appears in p13/p23/p33 position p33 after edge N+2.
REQ-024 post_* SHALL equal per_* delayed exactly 2 clk cycles.
REQ-025 Matrix registers SHALL hold when no accepted pixel; SHALL NOT be cleared at line or frame boundaries.
REQ-026 Pixel in same cycle as vsync rising edge SHALL NOT be accepted.
REQ-027 Frame with > IMG_HEIGHT href pulses: extras ignored, line_err set.

Reset
REQ-028 rst_n low SHALL immediately force: state IDLE, lb_shift 0, lb_sr_in 0, all matrix_p* 0, post_* 0, window_valid 0, col_cnt 0, row_cnt 0, line_err 0, pipeline registers 0.
REQ-029 Reset mid-frame: after release, no shift until next vsync rising edge; shift buffer contents not required clear.

Configuration
REQ-030 Macro BORDER_MASK_EN defined: window_valid = post_frame_clken & (accepted pixel) & row_cnt>=2 & col_cnt>=3 (column index of p33 >= 2).
REQ-031 BORDER_MASK_EN undefined: window_valid = post_frame_clken delayed-accept flag only; border windows flagged valid.

Verification
REQ-032 Reset, vsync pulse, 4 lines x 640 pixels all 1 -> lb_shift pulses 2560 total, row_cnt=4, line_err=0.
REQ-033 Line 2 col 5 pixel=1, rest 0 -> matrix p33=1 two cycles after that pixel's clken; p23=1 at same col next line; p13=1 line after.
REQ-034 Line of 642 pixels -> lb_shift=0 for last 2, col_cnt=640, line_err=1; cleared by next vsync rising edge.
REQ-035 481 lines -> FRAME_DONE after 480th, 481st line no lb_shift, line_err=1.
REQ-036 rst_n low mid-line 100 -> all outputs 0 asynchronously; after release, pixels before vsync cause no lb_shift.
REQ-037 With BORDER_MASK_EN: window_valid=0 for rows 0-1 and cols 0-1; =1 at row 2 col 2; without: =1 from first pixel.

Source files
------------

// File: rtl/line_buf_ctrl.sv
// 3x3 binary window generator that drives an external two-line shift buffer.
// Optional BORDER_MASK_EN: window_valid is suppressed for windows touching the top/left border.
module line_buf_ctrl #(
    parameter int unsigned IMG_WIDTH  = 640,
    parameter int unsigned IMG_HEIGHT = 480
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       per_frame_vsync,
    input  logic       per_frame_href,
    input  logic       per_frame_clken,
    input  logic       per_img_bit,
    output logic       lb_shift,
    output logic       lb_sr_in,
    input  logic [1:0] lb_taps,
    output logic       matrix_p11,
    output logic       matrix_p12,
    output logic       matrix_p13,
    output logic       matrix_p21,
    output logic       matrix_p22,
    output logic       matrix_p23,
    output logic       matrix_p31,
    output logic       matrix_p32,
    output logic       matrix_p33,
    output logic       post_frame_vsync,
    output logic       post_frame_href,
    output logic       post_frame_clken,
    output logic       window_valid,
    output logic [9:0] col_cnt,
    output logic [8:0] row_cnt,
    output logic       line_err
);

    localparam int unsigned COL_W = 10;
    localparam int unsigned ROW_W = 9;

    localparam logic [1:0] IDLE       = 2'd0;
    localparam logic [1:0] WAIT_LINE  = 2'd1;
    localparam logic [1:0] LINE       = 2'd2;
    localparam logic [1:0] FRAME_DONE = 2'd3;

    logic [1:0]     state;
    logic [1:0]     state_nxt;

    logic           vsync_d1;
    logic           vsync_d2;
    logic           href_d1;
    logic           href_d2;
    logic           clken_d1;
    logic           clken_d2;
    logic           bit_d1;
    logic           acc_d1;

    logic           vsync_rise_c;
    logic           href_rise_c;
    logic           href_fall_c;
    logic           acc_c;
    logic           col_full_c;
    logic           row_last_c;
    logic           border_ok_c;
    logic [ROW_W:0] row_inc_c;

    assign vsync_rise_c = per_frame_vsync & ~vsync_d1;
    assign href_rise_c  = per_frame_href & ~href_d1;
    assign href_fall_c  = ~per_frame_href & href_d1;

    // A pixel coinciding with a new frame start is dropped.
    assign acc_c = per_frame_clken & per_frame_href & (state == LINE) & ~vsync_rise_c;

    assign col_full_c = (col_cnt == COL_W'(IMG_WIDTH));
    assign row_inc_c  = {1'b0, row_cnt} + (ROW_W + 1)'(1);
    assign row_last_c = (row_inc_c == (ROW_W + 1)'(IMG_HEIGHT));

    assign lb_shift = acc_d1 & ~col_full_c;
    assign lb_sr_in = bit_d1;

    assign post_frame_vsync = vsync_d2;
    assign post_frame_href  = href_d2;
    assign post_frame_clken = clken_d2;

`ifdef BORDER_MASK_EN
    // Pre-increment col_cnt is the column index of the pixel entering p33.
    assign border_ok_c = (row_cnt >= ROW_W'(2)) && (col_cnt >= COL_W'(2));
`else
    assign border_ok_c = 1'b1;
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; a vsync rising edge restarts the frame from any state
    always_comb begin
        state_nxt = state;
        if (vsync_rise_c) begin
            state_nxt = WAIT_LINE;
        end else begin
            case (state)
                IDLE:       state_nxt = IDLE;
                WAIT_LINE:  if (per_frame_href) state_nxt = LINE;
                LINE:       if (href_fall_c) state_nxt = row_last_c ? FRAME_DONE : WAIT_LINE;
                FRAME_DONE: state_nxt = FRAME_DONE;
                default:    state_nxt = IDLE;
            endcase
        end
    end

    // Sync delay line and input stage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vsync_d1 <= 1'b0;
            vsync_d2 <= 1'b0;
            href_d1  <= 1'b0;
            href_d2  <= 1'b0;
            clken_d1 <= 1'b0;
            clken_d2 <= 1'b0;
            bit_d1   <= 1'b0;
            acc_d1   <= 1'b0;
        end else begin
            vsync_d1 <= per_frame_vsync;
            vsync_d2 <= vsync_d1;
            href_d1  <= per_frame_href;
            href_d2  <= href_d1;
            clken_d1 <= per_frame_clken;
            clken_d2 <= clken_d1;
            bit_d1   <= per_img_bit;
            acc_d1   <= acc_c;
        end
    end

    // Column/row counters and sticky error flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_cnt  <= '0;
            row_cnt  <= '0;
            line_err <= 1'b0;
        end else if (vsync_rise_c) begin
            col_cnt  <= '0;
            row_cnt  <= '0;
            line_err <= 1'b0;
        end else begin
            if ((state == LINE) && href_fall_c) begin
                col_cnt <= '0;
                row_cnt <= row_inc_c[ROW_W-1:0];
            end else if (lb_shift) begin
                col_cnt <= col_cnt + COL_W'(1);
            end
            if ((acc_d1 && col_full_c) || ((state == FRAME_DONE) && href_rise_c)) begin
                line_err <= 1'b1;
            end
        end
    end

    // 3x3 window: new column enters on the right, taps give the two older lines
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            matrix_p11 <= 1'b0;
            matrix_p12 <= 1'b0;
            matrix_p13 <= 1'b0;
            matrix_p21 <= 1'b0;
            matrix_p22 <= 1'b0;
            matrix_p23 <= 1'b0;
            matrix_p31 <= 1'b0;
            matrix_p32 <= 1'b0;
            matrix_p33 <= 1'b0;
        end else if (lb_shift) begin
            matrix_p11 <= matrix_p12;
            matrix_p12 <= matrix_p13;
            matrix_p13 <= lb_taps[1];
            matrix_p21 <= matrix_p22;
            matrix_p22 <= matrix_p23;
            matrix_p23 <= lb_taps[0];
            matrix_p31 <= matrix_p32;
            matrix_p32 <= matrix_p33;
            matrix_p33 <= bit_d1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            window_valid <= 1'b0;
        end else begin
            window_valid <= lb_shift & clken_d1 & border_ok_c;
        end
    end

endmodule

// File: tb/tb_line_buf_ctrl.sv
// Randomized self-checking bench for line_buf_ctrl; models the two-line shift buffer and
// predicts the window from a stored image of the current frame.
module tb_line_buf_ctrl;

    localparam int unsigned W = 640;
    localparam int unsigned H = 480;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       per_frame_vsync = 1'b0;
    logic       per_frame_href = 1'b0;
    logic       per_frame_clken = 1'b0;
    logic       per_img_bit = 1'b0;
    logic       lb_shift;
    logic       lb_sr_in;
    logic [1:0] lb_taps;
    logic       matrix_p11, matrix_p12, matrix_p13;
    logic       matrix_p21, matrix_p22, matrix_p23;
    logic       matrix_p31, matrix_p32, matrix_p33;
    logic       post_frame_vsync, post_frame_href, post_frame_clken;
    logic       window_valid;
    logic [9:0] col_cnt;
    logic [8:0] row_cnt;
    logic       line_err;

    int n_cmp = 0;
    int n_fail = 0;
    int shift_cnt = 0;

    // Frame model: completed lines, frame-done flag, expected sticky error
    int m_row = 0;
    bit m_done = 1'b0;
    bit m_err = 1'b0;
    bit img [0:7][0:1023];

    logic [2*W-1:0] sr = '0;

    line_buf_ctrl #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
        .clk(clk), .rst_n(rst_n),
        .per_frame_vsync(per_frame_vsync), .per_frame_href(per_frame_href),
        .per_frame_clken(per_frame_clken), .per_img_bit(per_img_bit),
        .lb_shift(lb_shift), .lb_sr_in(lb_sr_in), .lb_taps(lb_taps),
        .matrix_p11(matrix_p11), .matrix_p12(matrix_p12), .matrix_p13(matrix_p13),
        .matrix_p21(matrix_p21), .matrix_p22(matrix_p22), .matrix_p23(matrix_p23),
        .matrix_p31(matrix_p31), .matrix_p32(matrix_p32), .matrix_p33(matrix_p33),
        .post_frame_vsync(post_frame_vsync), .post_frame_href(post_frame_href),
        .post_frame_clken(post_frame_clken), .window_valid(window_valid),
        .col_cnt(col_cnt), .row_cnt(row_cnt), .line_err(line_err)
    );

    always #5 clk = ~clk;

    // External two-line shift buffer
    assign lb_taps = {sr[2*W-1], sr[W-1]};
    always @(posedge clk) if (lb_shift === 1'b1) sr <= {sr[2*W-2:0], lb_sr_in};

    always @(negedge clk) if (lb_shift === 1'b1) shift_cnt <= shift_cnt + 1;

    function automatic bit exp_border(input int r, input int j);
`ifdef BORDER_MASK_EN
        return (r >= 2) && (j >= 2);
`else
        return (r >= 0) && (j >= 0);
`endif
    endfunction

    function automatic logic [8:0] exp_win(input int r, input int j);
        int a, b, c;
        a = (r - 2) % 8;
        b = (r - 1) % 8;
        c = r % 8;
        return {img[a][j-2], img[a][j-1], img[a][j],
                img[b][j-2], img[b][j-1], img[b][j],
                img[c][j-2], img[c][j-1], img[c][j]};
    endfunction

    // mode 0: zeros, 1: ones, 2: random
    task automatic set_line(input int r, input int mode, input int n);
        for (int c = 0; c < n; c++)
            img[r % 8][c] = (mode == 0) ? 1'b0 : (mode == 1) ? 1'b1 : 1'($urandom);
    endtask

    task automatic vsync_pulse();
        @(posedge clk); #1;
        per_frame_vsync = 1'b0; per_frame_href = 1'b0; per_frame_clken = 1'b0; per_img_bit = 1'b0;
        @(posedge clk); #1; per_frame_vsync = 1'b1;
        @(posedge clk); #1; per_frame_vsync = 1'b0;
        @(posedge clk); #1;
        m_row = 0; m_done = 1'b0; m_err = 1'b0;
    endtask

    // One line: href lead cycle, n pixels, two drain cycles, then two href-low cycles
    task automatic send_line(input int n, input bit chk_mat);
        int r, j, s0, ecol;
        bit acc, ewv;
        logic [8:0] gw, ew;
        r = m_row; acc = !m_done; s0 = shift_cnt;
        ecol = acc ? ((n < W) ? n : W) : 0;
        for (int k = 0; k < n + 3; k++) begin
            @(posedge clk); #1;
            per_frame_href  = 1'b1;
            per_frame_clken = (k >= 1) && (k <= n);
            per_img_bit     = ((k >= 1) && (k <= n)) ? img[r % 8][k - 1] : 1'b0;
            @(negedge clk);
            j = k - 3;
            if (j >= 0) begin
                ewv = acc && (j < W) && exp_border(r, j);
                n_cmp++;
                if (window_valid !== ewv) begin
                    n_fail++;
                    $display("FAIL window_valid r%0d c%0d: got %b want %b", r, j, window_valid, ewv);
                end
                if (chk_mat && acc && (j < W) && (r >= 2) && (j >= 2)) begin
                    gw = {matrix_p11, matrix_p12, matrix_p13, matrix_p21, matrix_p22,
                          matrix_p23, matrix_p31, matrix_p32, matrix_p33};
                    ew = exp_win(r, j);
                    n_cmp++;
                    if (gw !== ew) begin
                        n_fail++;
                        $display("FAIL matrix r%0d c%0d: got %b want %b", r, j, gw, ew);
                    end
                end
            end
        end
        n_cmp++;
        if (col_cnt !== 10'(ecol)) begin
            n_fail++;
            $display("FAIL col_cnt end of line r%0d: got %0d want %0d", r, col_cnt, ecol);
        end
        for (int g = 0; g < 2; g++) begin
            @(posedge clk); #1;
            per_frame_href = 1'b0; per_frame_clken = 1'b0; per_img_bit = 1'b0;
        end
        @(negedge clk);
        if (acc) begin
            m_row++;
            if (m_row == H) m_done = 1'b1;
        end else begin
            m_err = 1'b1;
        end
        if (n > W) m_err = 1'b1;
        n_cmp++;
        if ((row_cnt !== 9'(m_row)) || (col_cnt !== 10'd0) || (line_err !== m_err)) begin
            n_fail++;
            $display("FAIL line_end r%0d: got row %0d col %0d err %b want row %0d col 0 err %b",
                     r, row_cnt, col_cnt, line_err, m_row, m_err);
        end
        n_cmp++;
        if (shift_cnt - s0 != ecol) begin
            n_fail++;
            $display("FAIL shifts r%0d: got %0d want %0d", r, shift_cnt - s0, ecol);
        end
    endtask

    task automatic test_reset();
        logic [15:0] got;
        repeat (3) @(posedge clk);
        #1;
        got = {lb_shift, lb_sr_in, matrix_p11, matrix_p12, matrix_p13, matrix_p21, matrix_p22,
               matrix_p23, matrix_p31, matrix_p32, matrix_p33, post_frame_vsync, post_frame_href,
               post_frame_clken, window_valid, line_err};
        n_cmp++;
        if ((got !== 16'h0) || (col_cnt !== 10'd0) || (row_cnt !== 9'd0)) begin
            n_fail++;
            $display("FAIL reset: got flags %h col %0d row %0d want 0 0 0", got, col_cnt, row_cnt);
        end
        @(posedge clk); #3; rst_n = 1'b1;
    endtask

    task automatic test_post_delay();
        logic [2:0] h0, h1, cur, got;
        h0 = '0; h1 = '0;
        for (int k = 0; k < 60; k++) begin
            @(posedge clk); #1;
            cur = (k >= 57) ? 3'b000 : 3'($urandom);
            {per_frame_vsync, per_frame_href, per_frame_clken} = cur;
            per_img_bit = 1'($urandom);
            @(negedge clk);
            if (k >= 2) begin
                got = {post_frame_vsync, post_frame_href, post_frame_clken};
                n_cmp++;
                if (got !== h1) begin
                    n_fail++;
                    $display("FAIL post_delay k%0d: got %b want %b", k, got, h1);
                end
            end
            h1 = h0; h0 = cur;
        end
    endtask

    task automatic test_full_lines();
        int s0;
        vsync_pulse();
        s0 = shift_cnt;
        for (int r = 0; r < 4; r++) begin
            set_line(r, 1, W);
            send_line(W, 1'b1);
        end
        n_cmp++;
        if ((shift_cnt - s0 != 4 * W) || (row_cnt !== 9'd4) || (line_err !== 1'b0)) begin
            n_fail++;
            $display("FAIL full_lines: got shifts %0d row %0d err %b want 2560 4 0",
                     shift_cnt - s0, row_cnt, line_err);
        end
    endtask

    task automatic test_dot();
        vsync_pulse();
        for (int r = 0; r < 5; r++) begin
            set_line(r, 0, W);
            if (r == 2) img[2][5] = 1'b1;
            send_line(W, 1'b1);
        end
    endtask

    task automatic test_random_window();
        vsync_pulse();
        for (int r = 0; r < 4; r++) begin
            set_line(r, 2, W);
            send_line(W, 1'b1);
        end
    endtask

    task automatic test_random_lines();
        int n;
        vsync_pulse();
        for (int r = 0; r < 10; r++) begin
            n = int'($urandom_range(1, 30));
            set_line(r, 2, n);
            send_line(n, 1'b0);
        end
    endtask

    task automatic test_overlong();
        vsync_pulse();
        set_line(0, 2, W + 2);
        send_line(W + 2, 1'b0);
        vsync_pulse();
        @(negedge clk);
        n_cmp++;
        if ((line_err !== 1'b0) || (col_cnt !== 10'd0) || (row_cnt !== 9'd0)) begin
            n_fail++;
            $display("FAIL overlong_clear: got err %b col %0d row %0d want 0 0 0",
                     line_err, col_cnt, row_cnt);
        end
    endtask

    task automatic test_vsync_pixel();
        int s0;
        vsync_pulse();
        s0 = shift_cnt;
        @(posedge clk); #1; per_frame_href = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1; per_frame_clken = 1'b1; per_img_bit = 1'b1;
        end
        @(posedge clk); #1; per_frame_vsync = 1'b1;
        @(posedge clk); #1;
        per_frame_vsync = 1'b0; per_frame_href = 1'b0; per_frame_clken = 1'b0; per_img_bit = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if ((shift_cnt - s0 != 5) || (col_cnt !== 10'd0) || (row_cnt !== 9'd0)) begin
            n_fail++;
            $display("FAIL vsync_pixel: got shifts %0d col %0d row %0d want 5 0 0",
                     shift_cnt - s0, col_cnt, row_cnt);
        end
        m_row = 0; m_done = 1'b0; m_err = 1'b0;
    endtask

    task automatic test_frame_done();
        vsync_pulse();
        for (int r = 0; r < H + 1; r++) begin
            set_line(r, 2, 4);
            send_line(4, 1'b0);
        end
        n_cmp++;
        if ((row_cnt !== 9'(H)) || (line_err !== 1'b1)) begin
            n_fail++;
            $display("FAIL frame_done: got row %0d err %b want 480 1", row_cnt, line_err);
        end
    endtask

    task automatic test_reset_mid();
        logic [15:0] got;
        int s0;
        vsync_pulse();
        @(posedge clk); #1; per_frame_href = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1; per_frame_clken = 1'b1; per_img_bit = 1'b1;
        end
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        got = {lb_shift, lb_sr_in, matrix_p11, matrix_p12, matrix_p13, matrix_p21, matrix_p22,
               matrix_p23, matrix_p31, matrix_p32, matrix_p33, post_frame_vsync, post_frame_href,
               post_frame_clken, window_valid, line_err};
        n_cmp++;
        if ((got !== 16'h0) || (col_cnt !== 10'd0) || (row_cnt !== 9'd0)) begin
            n_fail++;
            $display("FAIL reset_mid: got flags %h col %0d row %0d want 0 0 0", got, col_cnt, row_cnt);
        end
        @(posedge clk); #3; rst_n = 1'b1;
        s0 = shift_cnt;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            per_frame_href = 1'b1; per_frame_clken = 1'b1; per_img_bit = 1'($urandom);
        end
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            per_frame_href = 1'b0; per_frame_clken = 1'b0; per_img_bit = 1'b0;
        end
        @(negedge clk);
        n_cmp++;
        if ((shift_cnt - s0 != 0) || (col_cnt !== 10'd0) || (row_cnt !== 9'd0)) begin
            n_fail++;
            $display("FAIL reset_mid_noshift: got shifts %0d col %0d row %0d want 0 0 0",
                     shift_cnt - s0, col_cnt, row_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_post_delay();
        test_full_lines();
        test_dot();
        test_random_window();
        test_random_lines();
        test_overlong();
        test_vsync_pixel();
        test_frame_done();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
